// File: rtl/mr_wb_pkg.sv
// Shared Wishbone B4 types and constants for the arbiter slice.
package mr_wb_pkg;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam int WB_AW = 30;
  localparam int WB_DW = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [WB_AW-1:0]     adr;
    logic [WB_DW-1:0]     dat;
    logic [WB_DW/8-1:0]   sel;
  } wb_m_req_t;

  typedef struct packed {
    logic ack;
    logic err;
    logic stall;
  } wb_m_rsp_t;
endpackage

// File: rtl/rr_prio_picker.sv
// Combinational request picker: round-robin from ptr+1 or fixed lowest-index.
module rr_prio_picker
  import mr_wb_pkg::*;
#(
  parameter int N       = 4,
  parameter int RR_MODE = ARB_RR,
  localparam int GW     = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [GW-1:0] gnt_idx_o
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [GW-1:0]  start;
  logic           unused_bits;

  always_comb begin : pick
    int w;
    if (RR_MODE == ARB_RR) start = (int'(ptr_i) >= N-1) ? '0 : ptr_i + GW'(1);
    else                   start = '0;
    // Rotating the doubled vector makes the wrap-around search a plain lowest-bit scan.
    dbl = {req_i, req_i} >> start;
    rot = dbl[N-1:0];
    w = 0;
    for (int j = N-1; j >= 0; j--) if (rot[j]) w = j;
    w = w + int'(start);
    if (w >= N) w = w - N;
    gnt_idx_o = GW'(w);
    gnt_oh_o  = '0;
    if (|req_i) gnt_oh_o[gnt_idx_o] = 1'b1;
  end

  assign unused_bits = ^{dbl[2*N-1:N], ptr_i};
endmodule

// File: rtl/wb_arbiter_n.sv
// N-master pipelined Wishbone B4 arbiter with per-grant outstanding limit and abort-safe response drop.
module wb_arbiter_n
  import mr_wb_pkg::*;
#(
  parameter int NUM_MASTERS     = 4,
  parameter int AW              = 30,
  parameter int DW              = 32,
  parameter int RR_MODE         = 1,
  parameter int MAX_OUTSTANDING = 4,
  localparam int GW             = $clog2(NUM_MASTERS),
  localparam int SW             = DW/8,
  localparam int CW             = $clog2(MAX_OUTSTANDING+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SW-1:0] m_sel_i,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [NUM_MASTERS-1:0]    m_stall_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  output logic [SW-1:0]             s_sel_o,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic                      s_stall_i,
  input  logic [DW-1:0]             s_dat_i,
  output logic [GW-1:0]             grant_o,
  output logic                      busy_o
);
  arb_state_e             state_q, state_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [GW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [GW-1:0]          pick_idx;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic                   limit, accept, rsp, live;
  logic                   unused_dat;

  rr_prio_picker #(.N(NUM_MASTERS), .RR_MODE(RR_MODE)) u_pick (
    .req_i     (m_cyc_i),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx)
  );

  assign limit = (cnt_q == CW'(MAX_OUTSTANDING));
  assign live  = (cnt_q != '0);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    m_stall_o = '1;
    accept    = 1'b0;
    rsp       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pick_oh) begin
          state_d = ST_OWNED;
          grant_d = pick_idx;
          ptr_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_OWNED: begin
        s_cyc_o = m_cyc_i[grant_q];
        s_stb_o = m_cyc_i[grant_q] & m_stb_i[grant_q] & ~limit;
        s_we_o  = m_we_i[grant_q];
        s_adr_o = m_adr_i[grant_q*AW +: AW];
        s_dat_o = m_dat_i[grant_q*DW +: DW];
        s_sel_o = m_sel_i[grant_q*SW +: SW];
        m_stall_o[grant_q] = s_stall_i | limit;
        // A zero count means nothing is owed to this owner: late responses die here.
        m_ack_o[grant_q]   = s_ack_i & live;
        m_err_o[grant_q]   = s_err_i & live;
        accept = s_stb_o & ~s_stall_i;
        rsp    = (s_ack_i | s_err_i) & live;
        if (!m_cyc_i[grant_q]) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (accept && !rsp) begin
          cnt_d = cnt_q + CW'(1);
        end else if (rsp && !accept) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= GW'(NUM_MASTERS-1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o    = grant_q;
  assign busy_o     = (state_q == ST_OWNED);
  // Read data is fanned out to the masters outside this block.
  assign unused_dat = ^s_dat_i;
endmodule

// File: tb/tb_wb_arbiter_n.sv
// Directed + randomized bench for wb_arbiter_n: a round-robin/MAX=4 and a fixed/MAX=2 instance.
module tb_wb_arbiter_n;
  localparam int N = 4, AW = 30, DW = 32, SW = 4, GW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    cyc, stb, we;
  logic [N*AW-1:0] adr;
  logic [N*DW-1:0] dat;
  logic [N*SW-1:0] sel;
  logic            s_ack, s_err, s_stall;
  logic [DW-1:0]   s_dat;

  logic [N-1:0]  o_ack[2], o_err[2], o_stall[2];
  logic          o_cyc[2], o_stb[2], o_we[2], o_busy[2];
  logic [AW-1:0] o_adr[2];
  logic [DW-1:0] o_dat[2];
  logic [SW-1:0] o_sel[2];
  logic [GW-1:0] o_gnt[2];

  wb_arbiter_n #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .RR_MODE(1), .MAX_OUTSTANDING(4)) dut_a (
    .clk(clk), .rst(rst), .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_adr_i(adr),
    .m_dat_i(dat), .m_sel_i(sel), .m_ack_o(o_ack[0]), .m_err_o(o_err[0]), .m_stall_o(o_stall[0]),
    .s_cyc_o(o_cyc[0]), .s_stb_o(o_stb[0]), .s_we_o(o_we[0]), .s_adr_o(o_adr[0]),
    .s_dat_o(o_dat[0]), .s_sel_o(o_sel[0]), .s_ack_i(s_ack), .s_err_i(s_err),
    .s_stall_i(s_stall), .s_dat_i(s_dat), .grant_o(o_gnt[0]), .busy_o(o_busy[0]));

  wb_arbiter_n #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .RR_MODE(0), .MAX_OUTSTANDING(2)) dut_b (
    .clk(clk), .rst(rst), .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_adr_i(adr),
    .m_dat_i(dat), .m_sel_i(sel), .m_ack_o(o_ack[1]), .m_err_o(o_err[1]), .m_stall_o(o_stall[1]),
    .s_cyc_o(o_cyc[1]), .s_stb_o(o_stb[1]), .s_we_o(o_we[1]), .s_adr_o(o_adr[1]),
    .s_dat_o(o_dat[1]), .s_sel_o(o_sel[1]), .s_ack_i(s_ack), .s_err_i(s_err),
    .s_stall_i(s_stall), .s_dat_i(s_dat), .grant_o(o_gnt[1]), .busy_o(o_busy[1]));

  // Reference model: owner (-1 = bus free), debts owed to the owner, last winner.
  int own[2], cnt[2], ptr[2], gidx[2];
  int mode[2] = '{1, 0};
  int mx[2]   = '{4, 2};
  int checks = 0, failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int d);
    logic [N-1:0] e_ack, e_err, e_stall;
    logic e_cyc, e_stb, e_we, e_busy, lim, live;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    string p;
    int g;
    p = (d == 0) ? "a_" : "b_";
    e_ack = '0; e_err = '0; e_stall = '1;
    e_cyc = 0; e_stb = 0; e_we = 0; e_busy = 0;
    e_adr = '0; e_dat = '0; e_sel = '0;
    if (own[d] >= 0) begin
      g    = own[d];
      lim  = (cnt[d] == mx[d]);
      live = (cnt[d] != 0);
      e_cyc = cyc[g];
      e_stb = cyc[g] & stb[g] & ~lim;
      e_we  = we[g];
      e_adr = adr[g*AW +: AW];
      e_dat = dat[g*DW +: DW];
      e_sel = sel[g*SW +: SW];
      e_stall[g] = s_stall | lim;
      e_ack[g]   = s_ack & live;
      e_err[g]   = s_err & live;
      e_busy = 1;
    end
    chk({p, "cyc"},   64'(o_cyc[d]),   64'(e_cyc));
    chk({p, "stb"},   64'(o_stb[d]),   64'(e_stb));
    chk({p, "we"},    64'(o_we[d]),    64'(e_we));
    chk({p, "adr"},   64'(o_adr[d]),   64'(e_adr));
    chk({p, "dat"},   64'(o_dat[d]),   64'(e_dat));
    chk({p, "sel"},   64'(o_sel[d]),   64'(e_sel));
    chk({p, "ack"},   64'(o_ack[d]),   64'(e_ack));
    chk({p, "err"},   64'(o_err[d]),   64'(e_err));
    chk({p, "stall"}, 64'(o_stall[d]), 64'(e_stall));
    chk({p, "busy"},  64'(o_busy[d]),  64'(e_busy));
    chk({p, "grant"}, 64'(o_gnt[d]),   64'(gidx[d]));
  endtask

  task automatic model_step(input int d);
    int w, c, g;
    bit found, lim, acc, rsp;
    if (rst) begin
      own[d] = -1; gidx[d] = 0; ptr[d] = N-1; cnt[d] = 0;
    end else if (own[d] < 0) begin
      found = 0; w = 0;
      for (int k = 0; k < N; k++) begin
        c = (mode[d] == 1) ? (ptr[d] + 1 + k) % N : k;
        if (!found && cyc[c]) begin found = 1; w = c; end
      end
      if (found) begin own[d] = w; gidx[d] = w; ptr[d] = w; cnt[d] = 0; end
    end else begin
      g = own[d];
      if (!cyc[g]) begin
        own[d] = -1; cnt[d] = 0;
      end else begin
        lim = (cnt[d] == mx[d]);
        acc = stb[g] && !lim && !s_stall;
        rsp = (s_ack || s_err) && cnt[d] != 0;
        cnt[d] = cnt[d] + int'(acc) - int'(rsp);
      end
    end
  endtask

  task automatic tick();
    #1;
    if (chk_en) begin check_dut(0); check_dut(1); end
    @(posedge clk);
    model_step(0); model_step(1);
    #1;
  endtask

  task automatic clear_inputs();
    cyc = '0; stb = '0; we = '0; adr = '0; dat = '0; sel = '0;
    s_ack = 0; s_err = 0; s_stall = 0; s_dat = '0;
  endtask

  task automatic do_reset();
    rst = 1; clear_inputs(); tick(); rst = 0;
  endtask

  task automatic chk_reset_vals(input string tag, input int d);
    chk({tag, "_busy"},  64'(o_busy[d]),  64'(0));
    chk({tag, "_scyc"},  64'(o_cyc[d]),   64'(0));
    chk({tag, "_sstb"},  64'(o_stb[d]),   64'(0));
    chk({tag, "_ack"},   64'(o_ack[d]),   64'(0));
    chk({tag, "_stall"}, 64'(o_stall[d]), 64'(4'hf));
    chk({tag, "_grant"}, 64'(o_gnt[d]),   64'(0));
  endtask

  task automatic rr_run(input int d, input logic [15:0] seq);
    int g;
    do_reset();
    cyc[1] = 1; cyc[3] = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      g = int'(o_gnt[d]);
      chk((d == 0) ? "t2_busy_rr" : "t2_busy_fixed", 64'(o_busy[d]), 64'(1));
      chk((d == 0) ? "t2_rr_order" : "t2_fixed_order", 64'(o_gnt[d]), 64'(seq[k*4 +: 4]));
      stb[g] = 1; tick();
      stb[g] = 0; s_ack = 1; tick();
      s_ack = 0; cyc[g] = 0; tick();
      cyc[g] = 1;
    end
    cyc = '0; tick(); tick();
  endtask

  initial begin
    int acks, other, sent, acked, pend, first_ack_acc;
    logic acc;
    for (int d = 0; d < 2; d++) begin own[d] = -1; cnt[d] = 0; ptr[d] = N-1; gidx[d] = 0; end

    rst = 1; clear_inputs(); tick(); tick();
    chk_en = 1; rst = 0;
    #1;
    chk_reset_vals("rst_a", 0);
    chk_reset_vals("rst_b", 1);

    // Single master, three pipelined reads, 1-cycle ack slave.
    cyc[0] = 1; stb[0] = 1; adr[0 +: AW] = AW'(32'h10);
    #1; chk("t1_cyc_at_req", 64'(o_cyc[0]), 64'(0));
    tick();
    acks = 0; other = 0;
    for (int i = 0; i < 4; i++) begin
      stb[0] = (i < 3);
      adr[0 +: AW] = AW'(32'h10 + i);
      s_ack = (i >= 1);
      #1;
      if (i == 0) chk("t1_cyc_next", 64'(o_cyc[0]), 64'(1));
      if (i < 3) chk("t1_adr", 64'(o_adr[0]), 64'(32'h10 + i));
      acks  += int'(o_ack[0][0]);
      other += int'(|o_ack[0][3:1]) + int'(|o_ack[1][3:1]);
      tick();
    end
    s_ack = 0; stb = '0;
    #1;
    chk("t1_acks", 64'(acks), 64'(3));
    chk("t1_other_ack", 64'(other), 64'(0));
    chk("t1_cnt_zero", 64'(dut_a.cnt_q), 64'(0));
    cyc = '0; tick(); tick();

    // Masters 1 and 3 contend with back-to-back one-access cycles.
    rr_run(0, 16'h3131);
    rr_run(1, 16'h1111);

    // Outstanding limit of 2 on the fixed instance, slave acks held off 5 cycles.
    do_reset();
    cyc[0] = 1; tick();
    sent = 0; acked = 0; pend = 0; first_ack_acc = -1;
    for (int c = 0; c < 30 && acked < 4; c++) begin
      stb[0] = (sent < 4);
      adr[0 +: AW] = AW'(sent);
      s_ack = (c >= 5 && pend > 0);
      #1;
      acc = o_stb[1] & ~s_stall;
      if (pend == 2) chk("t3_stall_at_limit", 64'(o_stall[1][0]), 64'(1));
      if (pend < 2)  chk("t3_stall_below_limit", 64'(o_stall[1][0]), 64'(0));
      if (s_ack && first_ack_acc < 0) first_ack_acc = sent;
      tick();
      if (acc) begin sent++; pend++; end
      if (s_ack) begin acked++; pend--; end
    end
    chk("t3_acc_before_ack", 64'(first_ack_acc), 64'(2));
    chk("t3_sent", 64'(sent), 64'(4));
    chk("t3_acked", 64'(acked), 64'(4));
    stb = '0; cyc = '0; s_ack = 0; tick(); tick();

    // Abort with two strobes outstanding, late acks, master 2 waiting.
    do_reset();
    cyc[0] = 1; cyc[2] = 1; stb[0] = 1;
    tick(); tick(); tick();
    stb[0] = 0; cyc[0] = 0;
    #1;
    chk("t4_cyc_drop", 64'(o_cyc[0]), 64'(0));
    tick();
    s_ack = 1;
    #1;
    chk("t4_late_ack1", 64'({o_ack[0], o_ack[1]}), 64'(0));
    chk("t4_dead_cycle", 64'(o_cyc[0]), 64'(0));
    tick();
    #1;
    chk("t4_late_ack2", 64'({o_ack[0], o_ack[1]}), 64'(0));
    chk("t4_new_cyc", 64'(o_cyc[0]), 64'(1));
    chk("t4_new_grant", 64'(o_gnt[0]), 64'(2));
    tick();
    s_ack = 0; cyc = '0; tick(); tick();

    // Reset pulse while owned with three outstanding.
    do_reset();
    cyc[1] = 1; stb[1] = 1;
    tick(); tick(); tick(); tick();
    stb[1] = 0;
    #1;
    chk("t5_cnt3", 64'(dut_a.cnt_q), 64'(3));
    rst = 1; s_ack = 1; tick();
    rst = 0;
    #1;
    chk_reset_vals("t5_after_rst", 0);
    tick();
    s_ack = 0;
    #1;
    chk("t5_regrant_busy", 64'(o_busy[0]), 64'(1));
    chk("t5_regrant_idx", 64'(o_gnt[0]), 64'(1));
    chk("t5_regrant_cyc", 64'(o_cyc[0]), 64'(1));
    stb[1] = 1;
    #1;
    chk("t5_regrant_stb", 64'(o_stb[0]), 64'(1));
    tick();
    stb = '0; cyc = '0; tick(); tick();

    // Randomized traffic against the model on both instances.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int m = 0; m < N; m++) begin
        if ($urandom_range(0, 7) == 0) cyc[m] = ~cyc[m];
        stb[m] = 1'($urandom_range(0, 1));
        we[m]  = 1'($urandom_range(0, 1));
        adr[m*AW +: AW] = AW'($urandom());
        dat[m*DW +: DW] = $urandom();
        sel[m*SW +: SW] = SW'($urandom());
      end
      s_ack   = ($urandom_range(0, 2) == 0);
      s_err   = ($urandom_range(0, 9) == 0);
      s_stall = ($urandom_range(0, 3) == 0);
      s_dat   = $urandom();
      rst     = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0; clear_inputs(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
